// File: rtl/inv_mix_columns.sv
`default_nettype none
// ============================================================================
// Module   : inv_mix_columns
// Purpose  : AES InvMixColumns over a full 128-bit state, one register stage.
// Revision : 1.0
// ============================================================================
module inv_mix_columns (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [0:127] in,
  output logic [0:127] out,
  output logic         out_valid
);

  localparam logic [7:0] C_POLY_LOW = 8'h1B;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    xtime = {x[6:0], 1'b0} ^ (x[7] ? C_POLY_LOW : 8'h00);
  endfunction

  // All four coefficients share the x2/x4/x8 chain of one byte.
  function automatic logic [31:0] byte_products(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    // packed as {0E*x, 0B*x, 0D*x, 09*x}
    byte_products = {x8 ^ x4 ^ x2, x8 ^ x2 ^ x, x8 ^ x4 ^ x, x8 ^ x};
  endfunction

  logic [0:127] mix_w;
  logic [0:127] out_d, out_q;
  logic         valid_d, valid_q;

  generate
    for (genvar c = 0; c < 4; c++) begin : g_col
      logic [7:0]  a0, a1, a2, a3;
      logic [31:0] p0, p1, p2, p3;
      logic [7:0]  b0, b1, b2, b3;

      assign a0 = in[32*c      +: 8];
      assign a1 = in[32*c + 8  +: 8];
      assign a2 = in[32*c + 16 +: 8];
      assign a3 = in[32*c + 24 +: 8];

      assign p0 = byte_products(a0);
      assign p1 = byte_products(a1);
      assign p2 = byte_products(a2);
      assign p3 = byte_products(a3);

      // Slice map: [31:24]=0E, [23:16]=0B, [15:8]=0D, [7:0]=09.
      assign b0 = p0[31:24] ^ p1[23:16] ^ p2[15:8]  ^ p3[7:0];
      assign b1 = p0[7:0]   ^ p1[31:24] ^ p2[23:16] ^ p3[15:8];
      assign b2 = p0[15:8]  ^ p1[7:0]   ^ p2[31:24] ^ p3[23:16];
      assign b3 = p0[23:16] ^ p1[15:8]  ^ p2[7:0]   ^ p3[31:24];

      assign mix_w[32*c +: 32] = {b0, b1, b2, b3};
    end
  endgenerate

  always_comb begin
    out_d   = out_q;
    valid_d = in_valid;
    if (in_valid) begin
      out_d = mix_w;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_inv_mix_columns.sv
`default_nettype none
// ============================================================================
// Module   : tb_inv_mix_columns
// Purpose  : Directed and random checks of inv_mix_columns against a GF model.
// Revision : 1.0
// ============================================================================
module tb_inv_mix_columns;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [0:127] in;
  logic [0:127] out;
  logic         out_valid;

  int total;
  int bad;

  logic [0:127] exp_out;
  logic         exp_valid;

  inv_mix_columns dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in       (in),
    .out      (out),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generic shift-and-add multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] acc;
    acc = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) acc = acc ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (acc[i]) acc = acc ^ (16'h011B << (i - 8));
    return acc[7:0];
  endfunction

  function automatic logic [0:127] model(input logic [0:127] s);
    logic [7:0]   coef [4];
    logic [7:0]   a    [4];
    logic [7:0]   b;
    logic [0:127] r;
    coef[0] = 8'h0E; coef[1] = 8'h0B; coef[2] = 8'h0D; coef[3] = 8'h09;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[32*c + 8*j +: 8];
      for (int row = 0; row < 4; row++) begin
        b = 8'h00;
        // row r of the circulant matrix is the coefficient row rotated right by r
        for (int j = 0; j < 4; j++) b = b ^ gmul(coef[(j - row + 4) % 4], a[j]);
        r[32*c + 8*row +: 8] = b;
      end
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of input, advance one edge, and check against the model.
  task automatic drive_step(input string tag, input logic v, input logic [0:127] data);
    in_valid = v;
    in       = data;
    @(posedge clk);
    #1;
    if (v) exp_out = model(data);
    exp_valid = v;
    check({tag, "_valid"}, 128'(out_valid), 128'(exp_valid));
    check({tag, "_out"}, out, exp_out);
  endtask

  function automatic logic [0:127] place(input logic [31:0] col, input int pos);
    logic [127:0] t;
    t = {col, 96'h0} >> (32 * pos);
    return t;
  endfunction

  logic [31:0] col_in  [3];
  logic [31:0] col_out [3];
  logic [0:127] rnd;

  initial begin
    total = 0;
    bad   = 0;
    col_in[0] = 32'h8e4da1bc; col_out[0] = 32'hdb135345;
    col_in[1] = 32'h9fdc589d; col_out[1] = 32'hf20a225c;
    col_in[2] = 32'hd5d5d7d6; col_out[2] = 32'hd4d4d4d5;

    rst = 1'b1; in_valid = 1'b0; in = '0;
    exp_out = '0; exp_valid = 1'b0;
    #2;
    check("reset_out", out, 128'h0);
    check("reset_valid", 128'(out_valid), 128'h0);
    rst = 1'b0;

    drive_step("idle", 1'b0, '0);
    drive_step("idle2", 1'b0, '0);

    drive_step("full", 1'b1, 128'hbaa03de7a1f9b56ed5512cba5f414d23);
    check("full_known", out, 128'h3e1c22c0b6fcbf768da85067f6170495);

    // asynchronous reset with a nonzero result in the register
    #2 rst = 1'b1;
    #1;
    check("async_rst_out", out, 128'h0);
    check("async_rst_valid", 128'(out_valid), 128'h0);
    #1 rst = 1'b0;
    exp_out = '0; exp_valid = 1'b0;
    drive_step("post_rst_idle", 1'b0, '0);

    for (int v = 0; v < 3; v++)
      for (int p = 0; p < 4; p++) begin
        drive_step($sformatf("col%0d_pos%0d", v, p), 1'b1, place(col_in[v], p));
        check($sformatf("col%0d_pos%0d_known", v, p), out, place(col_out[v], p));
      end

    drive_step("zero", 1'b1, 128'h0);
    check("zero_known", out, 128'h0);
    drive_step("ones01", 1'b1, {16{8'h01}});
    check("ones01_known", out, {16{8'h01}});
    drive_step("c6", 1'b1, {16{8'hc6}});
    check("c6_known", out, {16{8'hc6}});

    for (int v = 0; v < 3; v++) begin
      drive_step($sformatf("stream%0d", v), 1'b1, place(col_in[v], 0));
      check($sformatf("stream%0d_known", v), out, place(col_out[v], 0));
    end
    drive_step("stream_drop", 1'b0, 128'hffffffff_ffffffff_ffffffff_ffffffff);
    check("stream_hold_known", out, place(col_out[2], 0));
    drive_step("stream_drop2", 1'b0, '0);

    // reset between two valid inputs
    drive_step("mid_a", 1'b1, place(col_in[1], 2));
    in_valid = 1'b1;
    in       = place(col_in[0], 3);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out", out, 128'h0);
    check("mid_rst_valid", 128'(out_valid), 128'h0);
    @(posedge clk);
    #1;
    check("mid_rst_held_valid", 128'(out_valid), 128'h0);
    rst = 1'b0;
    exp_out = '0; exp_valid = 1'b0;
    drive_step("mid_b", 1'b1, place(col_in[0], 3));
    check("mid_b_known", out, place(col_out[0], 3));

    for (int i = 0; i < 40; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      drive_step($sformatf("rand%0d", i), 1'($urandom_range(0, 3) != 0), rnd);
    end
    drive_step("rand_end", 1'b0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
